// File: rtl/data_mem_ctrl.sv
// Single-port data RAM with a valid/ready request port, a registered read response and a zero-fill sweep after reset.
// Optional stored even parity per word is enabled by defining DATA_MEM_PARITY_EN.
module data_mem_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    // state    | meaning
    // ST_CLEAR | zero-fill sweep, one word per cycle, requests blocked
    // ST_IDLE  | sweep done, one request accepted per cycle

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [PTR_W-1:0]  addr_idx;
    logic              accept;
    logic              in_range;
    logic              rd_err;
    logic [DATA_W-1:0] mem [DEPTH];

    // One extra address bit so DEPTH == 2**ADDR_W makes every address in range.
    assign in_range = {1'b0, req_addr} < DEPTH_EXT;
    assign addr_idx = req_addr[PTR_W-1:0];
    assign accept   = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy    = 1'b1;
                ptr_nxt = ptr + PTR_W'(1);
                if (ptr == LAST_PTR) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = '0;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR)
                mem[ptr] <= '0;
            else if (accept && req_write && in_range)
                mem[addr_idx] <= req_wdata;
        end
    end

`ifdef DATA_MEM_PARITY_EN
    logic par_mem [DEPTH];

    // Zero parity is the correct even parity for the zero words written by the sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR)
                par_mem[ptr] <= 1'b0;
            else if (accept && req_write && in_range)
                par_mem[addr_idx] <= ^req_wdata;
        end
    end

    assign rd_err = !in_range || ((^mem[addr_idx]) != par_mem[addr_idx]);
`else
    assign rd_err = !in_range;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= accept && !req_write;
            rsp_err   <= accept && (req_write ? !in_range : rd_err);
            if (accept && !req_write)
                rsp_rdata <= in_range ? mem[addr_idx] : '0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a full-depth instance and a DEPTH=200 instance share one stimulus stream.
// Define DATA_MEM_PARITY_EN for both the RTL and this file to exercise the stored-parity check.
module tb_data_mem_ctrl;
    localparam int DB = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_addr  = 8'h00;
    logic [7:0] req_wdata = 8'h00;

    logic       a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
    logic [7:0] a_rsp_rdata;
    logic       b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
    logic [7:0] b_rsp_rdata;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         due;
        logic       v;
        logic       e;
        logic [7:0] d;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] ma [256];
    logic [7:0] mb [DB];
    bit         pfa [256];

    exp_t ea, eb;
    bit   ha, hb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
    );

    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(DB)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(string nm, bit has, exp_t e, logic v, logic er, logic [7:0] d);
        if (has) begin
            chk($sformatf("%s rsp_valid", nm), 32'(v), 32'(e.v));
            chk($sformatf("%s rsp_err", nm), 32'(er), 32'(e.e));
            if (e.v) chk($sformatf("%s rsp_rdata", nm), 32'(d), 32'(e.d));
        end else begin
            checks++;
            if (v !== 1'b0 || er !== 1'b0) begin
                errors++;
                $display("FAIL %s unexpected output: valid=%0b err=%0b expected none (cycle %0d)",
                         nm, v, er, cyc);
            end
        end
    endtask

    // Monitor: responses are due exactly one cycle after the accepting edge.
    always @(negedge clk) begin
        ha = (qa.size() > 0) && (qa[0].due == cyc);
        hb = (qb.size() > 0) && (qb[0].due == cyc);
        ea = '{0, 1'b0, 1'b0, 8'h00};
        eb = '{0, 1'b0, 1'b0, 8'h00};
        if (ha) ea = qa.pop_front();
        if (hb) eb = qb.pop_front();
        mon("A", ha, ea, a_rsp_valid, a_rsp_err, a_rsp_rdata);
        mon("B", hb, eb, b_rsp_valid, b_rsp_err, b_rsp_rdata);
    end

    function automatic void clear_models();
        for (int i = 0; i < 256; i++) ma[i] = 8'h00;
        for (int i = 0; i < DB; i++) mb[i] = 8'h00;
        qa.delete();
        qb.delete();
    endfunction

    // Reference behaviour: plain arrays, out-of-range decided by each instance's depth.
    task automatic issue(bit wr, logic [7:0] a, logic [7:0] d);
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        if (wr) begin
            ma[a] = d;
            if (int'(a) < DB) mb[a] = d;
            else begin
                e = '{cyc + 1, 1'b0, 1'b1, 8'h00};
                qb.push_back(e);
            end
        end else begin
            e = '{cyc + 1, 1'b1, pfa[a], ma[a]};
            qa.push_back(e);
            if (int'(a) < DB) e = '{cyc + 1, 1'b1, 1'b0, mb[a]};
            else              e = '{cyc + 1, 1'b1, 1'b1, 8'h00};
            qb.push_back(e);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic count_busy(int exp_a, int exp_b);
        int na = 0;
        int nb = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (a_busy === 1'b1) na++;
            if (b_busy === 1'b1) nb++;
            chk("A req_ready vs busy", 32'(a_req_ready), 32'(a_busy !== 1'b1));
            chk("B req_ready vs busy", 32'(b_req_ready), 32'(b_busy !== 1'b1));
            if (a_busy !== 1'b1 && b_busy !== 1'b1) break;
        end
        chk("A clear cycles", 32'(na), 32'(exp_a));
        chk("B clear cycles", 32'(nb), 32'(exp_b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) pfa[i] = 1'b0;
        clear_models();

        // Reset values after the first reset edge.
        @(negedge clk);
        chk("A reset req_ready", 32'(a_req_ready), 0);
        chk("A reset busy", 32'(a_busy), 1);
        chk("A reset rsp_rdata", 32'(a_rsp_rdata), 0);
        chk("B reset req_ready", 32'(b_req_ready), 0);
        chk("B reset busy", 32'(b_busy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(256, DB);
        chk("A ready after sweep", 32'(a_req_ready), 1);
        chk("B ready after sweep", 32'(b_req_ready), 1);

        // Zero-filled contents, including the top address that is out of range for B.
        issue(1'b0, 8'h00, 8'h00);
        issue(1'b0, 8'd127, 8'h00);
        issue(1'b0, 8'd255, 8'h00);
        idle(2);

        // Read immediately after write.
        issue(1'b1, 8'h10, 8'hA5);
        issue(1'b0, 8'h10, 8'h00);
        idle(1);

        // Back-to-back reads.
        issue(1'b1, 8'h01, 8'h11);
        issue(1'b1, 8'h02, 8'h22);
        issue(1'b1, 8'h03, 8'h33);
        issue(1'b0, 8'h01, 8'h00);
        issue(1'b0, 8'h02, 8'h00);
        issue(1'b0, 8'h03, 8'h00);
        idle(2);

        // First address past B's depth, then its in-range neighbour.
        issue(1'b1, 8'hC8, 8'h5A);
        issue(1'b0, 8'hC8, 8'h00);
        issue(1'b0, 8'hC7, 8'h00);
        idle(2);

        // Parity fault injection on A; without the feature the same read reports no error.
        issue(1'b1, 8'h20, 8'h0F);
        idle(1);
`ifdef DATA_MEM_PARITY_EN
        force dut_a.par_mem[32] = 1'b1;
        pfa[32] = 1'b1;
`endif
        issue(1'b0, 8'h20, 8'h00);
        idle(2);
`ifdef DATA_MEM_PARITY_EN
        release dut_a.par_mem[32];
        pfa[32] = 1'b0;
`endif
        issue(1'b1, 8'h20, 8'h0F);
        issue(1'b0, 8'h20, 8'h00);
        idle(2);

        // Random traffic with gaps; a narrow address window forces read-after-write hits.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0) idle(1);
            else issue(1'(($urandom_range(0, 1))),
                       (r == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)),
                       8'($urandom));
        end
        idle(3);

        // Reset on the same edge that accepts a read: the response must be dropped.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h10;
        rst       = 1'b1;
        clear_models();
        @(negedge clk);
        chk("A no rsp after reset", 32'(a_rsp_valid), 0);
        chk("B no rsp after reset", 32'(b_rsp_valid), 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        count_busy(256, DB);

        // Reset at cycle 100 of the sweep restarts it from address 0.
        idle(1);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_models();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(256, DB);

        // Previously written words were cleared by the restarted sweep.
        issue(1'b0, 8'h10, 8'h00);
        issue(1'b0, 8'h01, 8'h00);
        issue(1'b0, 8'hC8, 8'h00);
        idle(3);

        chk("A scoreboard drained", 32'(qa.size()), 0);
        chk("B scoreboard drained", 32'(qb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised successor to the fixed 8-bit x 256 data memory. It is a single-port synchronous RAM with a valid/ready request interface, a registered read response, and an automatic zero-fill sweep after reset. It sits between the MCU datapath (load/store unit) and the data storage array. Every word has a defined value after reset, and out-of-range accesses are detected.

Parameters:
DATA_W, 8, data word width in bits (1..64)
ADDR_W, 8, request address width in bits
DEPTH, 256, number of implemented words; DEPTH <= 2**ADDR_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = write, 0 = read; sampled when req_valid && req_ready
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  read response valid, single-cycle pulse
rsp_rdata  output  DATA_W  read data, meaningful only when rsp_valid=1
rsp_err  output  1  out-of-range flag, qualified by rsp_valid or wr_err timing (see below)
busy  output  1  zero-fill sweep in progress

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1, state=CLEAR, clear pointer=0.
- FSM has two states.
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. When ptr==DEPTH-1 is written, go to IDLE on the next edge. CLEAR lasts exactly DEPTH cycles. During CLEAR, req_ready=0 and busy=1.
  - IDLE: req_ready=1 and busy=0. The block stays in IDLE until rst.
- Accept condition: req_valid && req_ready at a rising edge. At most one request is accepted per cycle. The block has no internal queue.
- Write, in-range (req_addr < DEPTH): mem[req_addr] <= req_wdata at the accepting edge. There is no response: rsp_valid stays 0.
- Write, out-of-range (req_addr >= DEPTH): memory is unchanged. rsp_err pulses 1 for the cycle after acceptance, with rsp_valid=0.
- Read, in-range: accepted at edge N. At edge N+1 the block drives rsp_valid=1, rsp_rdata=mem[req_addr], rsp_err=0. Fixed 1-cycle latency. The response cannot be back-pressured.
- Read, out-of-range: at edge N+1 the block drives rsp_valid=1, rsp_rdata=0, rsp_err=1.
- Read-after-write to the same address in consecutive cycles returns the newly written data.
- Back-to-back reads: one response per cycle, in request order.
- In any cycle with no read response: rsp_valid=0 and rsp_err=0 (except the out-of-range-write pulse). rsp_rdata holds its last value.
- Reset mid-operation: a pending response is cancelled (rsp_valid=0 on the cycle after rst), and the sweep restarts from address 0. Reset mid-CLEAR restarts the sweep.
- req_addr is compared at full ADDR_W width. When DEPTH == 2**ADDR_W, no address is out of range.

Optional Feature:
DATA_MEM_PARITY_EN
- Defined: each stored word carries one extra even-parity bit, computed on write (and set to 0 during CLEAR, which is correct parity for zero data). On every in-range read the parity is recomputed. On mismatch, rsp_err=1 alongside rsp_valid=1 and rsp_rdata carries the raw stored data. The bench needs a fault-injection hook: a hierarchical force on the stored parity bit.
- Undefined: no parity storage or check. rsp_err reports out-of-range only.

Test Plan:
1. Assert rst 2 cycles, then release -> busy=1 and req_ready=0 for exactly 256 cycles, then busy=0 and req_ready=1. Reading addresses 0, 127 and 255 returns 0x00 with rsp_err=0.
2. Write 0xA5 to 0x10, then read 0x10 on the next cycle -> rsp_valid=1 exactly one cycle after the read is accepted, rsp_rdata=0xA5, rsp_err=0.
3. Back-to-back reads of 0x01, 0x02, 0x03, previously written 0x11, 0x22, 0x33 -> three consecutive rsp_valid pulses with data 0x11, 0x22, 0x33 in order.
4. With DEPTH=200, ADDR_W=8: write 0x5A to 0xC8, then read 0xC8 -> write causes a one-cycle rsp_err pulse with rsp_valid=0. Read gives rsp_valid=1, rsp_rdata=0x00, rsp_err=1. Address 0xC7 stays unchanged.
5. Assert rst at cycle 100 of the CLEAR sweep, and separately on the same edge a read is accepted -> sweep restarts, busy=1 for 256 more cycles, no rsp_valid is emitted.
6. With DATA_MEM_PARITY_EN defined: write 0x0F to 0x20, force the parity bit flipped, then read 0x20 -> rsp_valid=1, rsp_rdata=0x0F, rsp_err=1. With the macro undefined, the same stimulus gives rsp_err=0.
